fir_coeff_ctrl: RTL and testbench
=================================

# fir_coeff_ctrl

Coefficient configuration controller for the FIR datapath. A host writes taps into a shadow bank through a valid/ready port. A commit handshake copies the shadow bank atomically into the active bank that drives the FIR coefficient inputs. After each commit the block counts input samples until the FIR delay line holds only post-commit history, and only then qualifies FIR output as valid.

## Interface

**Parameters**
- `COEFF_WIDTH`, 17: bits per signed coefficient.
- `N_TAPS`, 16: number of taps; legal range 2..64.
- `ADDR_WIDTH`, 6: tap address width; must satisfy 2^ADDR_WIDTH >= N_TAPS.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_wr_valid`, in, 1: host tap write request.
- `cfg_wr_ready`, out, 1: write may be accepted this cycle.
- `cfg_wr_addr`, in, ADDR_WIDTH: tap index.
- `cfg_wr_data`, in, COEFF_WIDTH: signed tap value.
- `cfg_commit_valid`, in, 1: host request to activate the shadow bank.
- `cfg_commit_ready`, out, 1: commit may be accepted this cycle.
- `sample_valid_in`, in, 1: one pulse per sample entering the FIR.
- `coeff_flat`, out, N_TAPS*COEFF_WIDTH: active bank; tap k occupies bits [k*COEFF_WIDTH +: COEFF_WIDTH].
- `fir_out_valid`, out, 1: FIR output is computed entirely with the active bank.
- `busy`, out, 1: high in COPY or SETTLE.
- `err_addr`, out, 1: sticky flag; set by a write with addr >= N_TAPS.

## Operation

**States:** EMPTY (reset state), COPY, SETTLE, ACTIVE.

**Writes**
- Accepted on `cfg_wr_valid && cfg_wr_ready`.
- `cfg_wr_ready` = 1 in every state except COPY.
- An accepted write with addr < N_TAPS updates shadow[addr].
- An accepted write with addr >= N_TAPS is dropped and sets `err_addr`. The flag clears only on reset.

**Commit**
- Accepted on `cfg_commit_valid && cfg_commit_ready`.
- `cfg_commit_ready` = 1 in EMPTY, SETTLE and ACTIVE; 0 in COPY.
- An accepted commit moves the FSM to COPY.

**State transitions**
- COPY lasts exactly one cycle: active <= shadow, settle counter <= N_TAPS, next state SETTLE.
- In SETTLE, each `sample_valid_in` decrements the counter. A sample arriving when the counter equals 1 moves the FSM to ACTIVE.
- ACTIVE holds until the next commit.
- `sample_valid_in` is ignored in EMPTY, COPY and ACTIVE.

**Boundary conditions**
- Write and commit accepted in the same cycle: the write lands in shadow at that edge and is included in the copy.
- Commit during SETTLE: accepted. Goes to COPY and the counter restarts from N_TAPS; no partial settle credit is kept.
- Commit during ACTIVE: `fir_out_valid` drops the cycle after acceptance.
- Commit with no writes since the last commit: still performs COPY and SETTLE.
- Unwritten shadow entries keep their last value (0 after reset).
- Reset mid-operation, any state: returns to EMPTY. Shadow, active, counter and `err_addr` all clear to 0.

**Reset values:** `cfg_wr_ready`=1, `cfg_commit_ready`=1, `coeff_flat`=0, `fir_out_valid`=0, `busy`=0, `err_addr`=0.

## Timing

- Commit accepted at edge T: COPY during cycle T..T+1, and `coeff_flat` shows the new bank from edge T+1.
- `busy` rises at T and stays high through SETTLE.
- All outputs are registered, except `cfg_wr_ready` and `cfg_commit_ready`, which decode the current state.
- `fir_out_valid` rises at the edge that registers the N_TAPS-th post-COPY `sample_valid_in`.
- No combinational path from any input to any output.

**Throughput**
- Writes: one per cycle outside COPY.
- Commits: back-to-back commits are accepted at most every 2 cycles.

## Test plan

- **Reset defaults:** assert `rst_n`=0 mid-run, then release. Expect `coeff_flat`=0, `fir_out_valid`=0, `busy`=0, `err_addr`=0, both readies =1, state EMPTY.
- **Load and settle:** write taps 0..15 = k+1, commit, then pulse `sample_valid_in` every 2 cycles.
  - `coeff_flat` tap k = k+1 one cycle after commit.
  - `fir_out_valid` stays 0 for the first 15 samples and is 1 after the 16th.
  - `busy` falls in the same cycle.
- **Write with commit, and write during COPY:**
  - Write addr 3 = -5 in the same cycle as the commit: active tap 3 = -5 after COPY.
  - A write held valid during COPY: `cfg_wr_ready`=0, and the write lands one cycle later in shadow only.
- **Recommit in SETTLE:** commit, feed 10 samples, commit again. `fir_out_valid` rises only after 16 samples following the second COPY.
- **Recommit in ACTIVE:** `fir_out_valid` goes 1→0 the cycle after commit acceptance.
- **Address error:** with N_TAPS=12, ADDR_WIDTH=4, write addr 13 = 7. `err_addr`=1 and stays sticky; after commit, no tap shows the value 7; `err_addr` clears only on reset.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: host writes a shadow tap bank, a commit copies it
// atomically into the active bank, and output is qualified once history settles.
module fir_coeff_ctrl #(
  parameter int COEFF_WIDTH = 17,
  parameter int N_TAPS      = 16,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_wr_valid,
  output logic                            cfg_wr_ready,
  input  logic [ADDR_WIDTH-1:0]           cfg_wr_addr,
  input  logic [COEFF_WIDTH-1:0]          cfg_wr_data,
  input  logic                            cfg_commit_valid,
  output logic                            cfg_commit_ready,
  input  logic                            sample_valid_in,
  output logic [N_TAPS*COEFF_WIDTH-1:0]   coeff_flat,
  output logic                            fir_out_valid,
  output logic                            busy,
  output logic                            err_addr
);

  localparam int CW = $clog2(N_TAPS + 1);
  localparam logic [ADDR_WIDTH:0] NT_A = (ADDR_WIDTH+1)'(N_TAPS);

  typedef enum logic [1:0] {EMPTY, COPY, SETTLE, ACTIVE} state_t;

  state_t                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [N_TAPS-1:0][COEFF_WIDTH-1:0]    shadow_q, active_q;
  logic                                  err_q, busy_q, fov_q;
  logic                                  wr_acc, cm_acc, addr_ok;

  assign cfg_wr_ready     = (state_q != COPY);
  assign cfg_commit_ready = (state_q != COPY);
  assign wr_acc  = cfg_wr_valid && cfg_wr_ready;
  assign cm_acc  = cfg_commit_valid && cfg_commit_ready;
  assign addr_ok = ({1'b0, cfg_wr_addr} < NT_A);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY, ACTIVE: if (cm_acc) state_d = COPY;
      COPY: begin
        state_d = SETTLE;
        cnt_d   = CW'(N_TAPS);
      end
      SETTLE: begin
        // A recommit discards any partial settle progress.
        if (cm_acc) state_d = COPY;
        else if (sample_valid_in) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ACTIVE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      fov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == COPY) || (state_d == SETTLE);
      fov_q   <= (state_d == ACTIVE);
      if (wr_acc && !addr_ok) err_q <= 1'b1;
      // Shadow write lands at the commit edge, so COPY picks it up next cycle.
      for (int k = 0; k < N_TAPS; k++)
        if (wr_acc && addr_ok && (cfg_wr_addr == ADDR_WIDTH'(k)))
          shadow_q[k] <= cfg_wr_data;
      if (state_q == COPY) active_q <= shadow_q;
    end
  end

  assign coeff_flat    = active_q;
  assign fir_out_valid = fov_q;
  assign busy          = busy_q;
  assign err_addr      = err_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: table-driven per-cycle vectors plus a
// scoreboard of expected active banks queued at each commit.
module tb_fir_coeff_ctrl;
  localparam int W = 17;
  localparam int N = 16;
  localparam int N2 = 12;

  logic clk, rst_n;
  logic wr_v, cm_v, smp;
  logic [5:0] wr_a;
  logic [W-1:0] wr_d;
  logic wr_rdy, cm_rdy, fov, bsy, err;
  logic [N*W-1:0] coeff;

  logic u2_wv, u2_cv, u2_sv;
  logic [3:0] u2_a;
  logic [W-1:0] u2_d;
  logic u2_wrdy, u2_crdy, u2_fov, u2_bsy, u2_err;
  logic [N2*W-1:0] u2_coeff;

  fir_coeff_ctrl #(.COEFF_WIDTH(W), .N_TAPS(N), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_valid(wr_v), .cfg_wr_ready(wr_rdy), .cfg_wr_addr(wr_a), .cfg_wr_data(wr_d),
    .cfg_commit_valid(cm_v), .cfg_commit_ready(cm_rdy), .sample_valid_in(smp),
    .coeff_flat(coeff), .fir_out_valid(fov), .busy(bsy), .err_addr(err));

  fir_coeff_ctrl #(.COEFF_WIDTH(W), .N_TAPS(N2), .ADDR_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_valid(u2_wv), .cfg_wr_ready(u2_wrdy), .cfg_wr_addr(u2_a), .cfg_wr_data(u2_d),
    .cfg_commit_valid(u2_cv), .cfg_commit_ready(u2_crdy), .sample_valid_in(u2_sv),
    .coeff_flat(u2_coeff), .fir_out_valid(u2_fov), .busy(u2_bsy), .err_addr(u2_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit wv; logic [5:0] a; logic signed [W-1:0] d;
    bit cv, sv, erw, erc, eb, ef;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic signed [W-1:0] sh [N];
  logic [N*W-1:0] sbq [$];
  bit pend = 1'b0;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wv, int a, int d, bit cv, bit sv, bit erw, bit erc, bit eb, bit ef);
    vec_t v;
    v.wv = wv; v.a = 6'(a); v.d = W'(d); v.cv = cv; v.sv = sv;
    v.erw = erw; v.erc = erc; v.eb = eb; v.ef = ef;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    logic [N*W-1:0] bank, exp_bank;
    logic signed [W-1:0] a_t, e_t;
    bit newpend;
    newpend = 1'b0;
    @(negedge clk);
    wr_v = v.wv; wr_a = v.a; wr_d = v.d; cm_v = v.cv; smp = v.sv;
    #1;
    chk({nm, " wr_ready"}, wr_rdy, v.erw);
    chk({nm, " commit_ready"}, cm_rdy, v.erc);
    if (v.wv && v.erw && v.a < N) sh[v.a] = v.d;
    if (v.cv && v.erc) begin
      for (int k = 0; k < N; k++) bank[k*W +: W] = sh[k];
      sbq.push_back(bank);
      newpend = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, " busy"}, bsy, v.eb);
    chk({nm, " fir_out_valid"}, fov, v.ef);
    if (pend) begin
      exp_bank = sbq.pop_front();
      for (int k = 0; k < N; k++) begin
        a_t = coeff[k*W +: W];
        e_t = exp_bank[k*W +: W];
        chk($sformatf("%s tap%0d", nm, k), a_t, e_t);
      end
      pend = 1'b0;
    end
    if (newpend) pend = 1'b1;
    wr_v = 1'b0; cm_v = 1'b0; smp = 1'b0;
  endtask

  task automatic chk_defaults(input string nm);
    chk({nm, " coeff zero"}, (coeff == '0), 1);
    chk({nm, " fov"}, fov, 0);
    chk({nm, " busy"}, bsy, 0);
    chk({nm, " err"}, err, 0);
    chk({nm, " wr_ready"}, wr_rdy, 1);
    chk({nm, " commit_ready"}, cm_rdy, 1);
    chk({nm, " u2 coeff zero"}, (u2_coeff == '0), 1);
    chk({nm, " u2 err"}, u2_err, 0);
    chk({nm, " u2 busy"}, u2_bsy, 0);
  endtask

  initial begin
    logic signed [W-1:0] t;
    rst_n = 1'b0;
    wr_v = 0; wr_a = '0; wr_d = '0; cm_v = 0; smp = 0;
    u2_wv = 0; u2_a = '0; u2_d = '0; u2_cv = 0; u2_sv = 0;
    for (int k = 0; k < N; k++) sh[k] = '0;
    repeat (3) @(negedge clk);
    chk_defaults("reset");
    rst_n = 1'b1;

    // Load taps k+1, commit, then a sample every other cycle.
    for (int k = 0; k < N; k++) tbl.push_back(mk(1, k, k + 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < N; i++) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, (i != N - 1), (i == N - 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, (i != N - 1), (i == N - 1)));
    end
    foreach (tbl[i]) step(tbl[i], $sformatf("load[%0d]", i));

    // Commit in ACTIVE with same-cycle write; write held through COPY.
    step(mk(1, 3, -5, 1, 0, 1, 1, 1, 0), "wr+commit");
    step(mk(1, 4, 99, 0, 0, 0, 0, 1, 0), "wr in copy");
    step(mk(1, 4, 99, 0, 0, 1, 1, 1, 0), "wr after copy");
    t = coeff[4*W +: W];
    chk("tap4 shadow only", t, 5);

    // Recommit after 10 samples of SETTLE; a sample during COPY is ignored.
    for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 0, 1, 1, 1, 1, 0), $sformatf("settle1[%0d]", i));
    step(mk(0, 0, 0, 1, 0, 1, 1, 1, 0), "recommit settle");
    step(mk(0, 0, 0, 0, 1, 0, 0, 1, 0), "copy sample");
    for (int i = 0; i < N; i++)
      step(mk(0, 0, 0, 0, 1, 1, 1, (i != N - 1), (i == N - 1)), $sformatf("settle2[%0d]", i));

    // Out-of-range address on the 12-tap instance.
    @(negedge clk);
    u2_wv = 1; u2_a = 4'd13; u2_d = W'(7);
    @(posedge clk); #1;
    chk("u2 err set", u2_err, 1);
    @(negedge clk);
    u2_a = 4'd2; u2_d = W'(9); u2_cv = 1;
    @(posedge clk); #1;
    u2_wv = 0; u2_cv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("u2 err sticky", u2_err, 1);
    chk("u2 busy", u2_bsy, 1);
    for (int k = 0; k < N2; k++) begin
      t = u2_coeff[k*W +: W];
      chk($sformatf("u2 tap%0d", k), t, (k == 2) ? 9 : 0);
    end

    // Mid-run reset during SETTLE, then a commit with no writes.
    step(mk(0, 0, 0, 1, 0, 1, 1, 1, 0), "commit pre-rst");
    step(mk(0, 0, 0, 0, 1, 0, 0, 1, 0), "copy pre-rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_defaults("midrun reset");
    for (int k = 0; k < N; k++) sh[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 0, 1, 0, 1, 1, 1, 0), "empty commit");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "empty copy");
    step(mk(0, 0, 0, 0, 1, 1, 1, 1, 0), "empty settle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
